// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU control generation, EX/MEM and MEM/WB
// operand forwarding, and load-use hazard detection for the decode stage.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [5:0]       in_opcode,
  input  logic [5:0]       in_funct,
  input  logic [RADDR-1:0] in_rs,
  input  logic [RADDR-1:0] in_rt,
  input  logic [RADDR-1:0] in_rd,
  input  logic [XLEN-1:0]  in_rs_data,
  input  logic [XLEN-1:0]  in_rt_data,
  input  logic [15:0]      in_imm,
  input  logic             exmem_regwrite,
  input  logic [RADDR-1:0] exmem_rd,
  input  logic [XLEN-1:0]  exmem_result,
  input  logic             memwb_regwrite,
  input  logic [RADDR-1:0] memwb_rd,
  input  logic [XLEN-1:0]  memwb_result,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [3:0]       alu_control,
  output logic             ex_valid,
  output logic             ex_regwrite,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic             ex_ovf_en,
  output logic             ex_illegal,
  output logic [RADDR-1:0] ex_dest,
  output logic [XLEN-1:0]  ex_store_data,
  output logic             load_use_hazard
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_XOR = 4'b1100;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  // Decoded (next-state) control fields
  logic             dec_regwrite_s;
  logic             dec_memread_s;
  logic             dec_memwrite_s;
  logic             dec_ovf_en_s;
  logic             dec_illegal_s;
  logic [3:0]       dec_alu_s;
  logic [RADDR-1:0] dec_dest_s;
  logic             dec_b_imm_s;
  logic [XLEN-1:0]  dec_imm_s;

  // ID/EX state
  logic             valid_r;
  logic             regwrite_r;
  logic             memread_r;
  logic             memwrite_r;
  logic             ovf_en_r;
  logic             illegal_r;
  logic [3:0]       alu_r;
  logic [RADDR-1:0] dest_r;
  logic [RADDR-1:0] rs_r;
  logic [RADDR-1:0] rt_r;
  logic [XLEN-1:0]  rs_data_r;
  logic [XLEN-1:0]  rt_data_r;
  logic [XLEN-1:0]  imm_r;
  logic             b_imm_r;

  // Forwarded operands
  logic [XLEN-1:0]  fwd_rs_s;
  logic [XLEN-1:0]  fwd_rt_s;

  logic [XLEN-1:0]  sext_imm_s;
  logic [XLEN-1:0]  zext_imm_s;

  assign sext_imm_s = {{(XLEN-16){in_imm[15]}}, in_imm};
  assign zext_imm_s = {{(XLEN-16){1'b0}}, in_imm};

  // Decode opcode/funct into ALU code, control bits, destination and B-source
  always_comb begin
    dec_regwrite_s = 1'b0;
    dec_memread_s  = 1'b0;
    dec_memwrite_s = 1'b0;
    dec_ovf_en_s   = 1'b0;
    dec_illegal_s  = 1'b0;
    dec_alu_s      = ALU_ADD;
    dec_dest_s     = {RADDR{1'b0}};
    dec_b_imm_s    = 1'b0;
    dec_imm_s      = sext_imm_s;
    case (in_opcode)
      OP_RTYPE: begin
        dec_regwrite_s = 1'b1;
        dec_dest_s     = in_rd;
        case (in_funct)
          FN_ADD:  begin dec_alu_s = ALU_ADD; dec_ovf_en_s = 1'b1; end
          FN_ADDU: dec_alu_s = ALU_ADD;
          FN_SUB:  begin dec_alu_s = ALU_SUB; dec_ovf_en_s = 1'b1; end
          FN_SUBU: dec_alu_s = ALU_SUB;
          FN_AND:  dec_alu_s = ALU_AND;
          FN_OR:   dec_alu_s = ALU_OR;
          FN_XOR:  dec_alu_s = ALU_XOR;
          FN_SLT:  dec_alu_s = ALU_SLT;
          default: begin
            dec_illegal_s  = 1'b1;
            dec_regwrite_s = 1'b0;
            dec_dest_s     = {RADDR{1'b0}};
          end
        endcase
      end
      OP_ADDI: begin
        dec_alu_s = ALU_ADD; dec_ovf_en_s = 1'b1; dec_regwrite_s = 1'b1;
        dec_dest_s = in_rt; dec_b_imm_s = 1'b1;
      end
      OP_ADDIU: begin
        dec_alu_s = ALU_ADD; dec_regwrite_s = 1'b1;
        dec_dest_s = in_rt; dec_b_imm_s = 1'b1;
      end
      OP_SLTI: begin
        dec_alu_s = ALU_SLT; dec_regwrite_s = 1'b1;
        dec_dest_s = in_rt; dec_b_imm_s = 1'b1;
      end
      OP_ANDI: begin
        dec_alu_s = ALU_AND; dec_regwrite_s = 1'b1;
        dec_dest_s = in_rt; dec_b_imm_s = 1'b1; dec_imm_s = zext_imm_s;
      end
      OP_ORI: begin
        dec_alu_s = ALU_OR; dec_regwrite_s = 1'b1;
        dec_dest_s = in_rt; dec_b_imm_s = 1'b1; dec_imm_s = zext_imm_s;
      end
      OP_XORI: begin
        dec_alu_s = ALU_XOR; dec_regwrite_s = 1'b1;
        dec_dest_s = in_rt; dec_b_imm_s = 1'b1; dec_imm_s = zext_imm_s;
      end
      OP_LW: begin
        dec_alu_s = ALU_ADD; dec_regwrite_s = 1'b1; dec_memread_s = 1'b1;
        dec_dest_s = in_rt; dec_b_imm_s = 1'b1;
      end
      OP_SW: begin
        dec_alu_s = ALU_ADD; dec_memwrite_s = 1'b1;
        dec_dest_s = in_rt; dec_b_imm_s = 1'b1;
      end
      OP_BEQ: begin
        dec_alu_s = ALU_SUB; dec_dest_s = in_rt;
      end
      default: dec_illegal_s = 1'b1;
    endcase
  end

  // ID/EX register: reset > flush > stall > load; empty decode slot loads a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r    <= 1'b0;
      regwrite_r <= 1'b0;
      memread_r  <= 1'b0;
      memwrite_r <= 1'b0;
      ovf_en_r   <= 1'b0;
      illegal_r  <= 1'b0;
      alu_r      <= 4'b0000;
      dest_r     <= {RADDR{1'b0}};
      rs_r       <= {RADDR{1'b0}};
      rt_r       <= {RADDR{1'b0}};
      rs_data_r  <= {XLEN{1'b0}};
      rt_data_r  <= {XLEN{1'b0}};
      imm_r      <= {XLEN{1'b0}};
      b_imm_r    <= 1'b0;
    end else if (flush || (!stall && !in_valid)) begin
      valid_r    <= 1'b0;
      regwrite_r <= 1'b0;
      memread_r  <= 1'b0;
      memwrite_r <= 1'b0;
      ovf_en_r   <= 1'b0;
      illegal_r  <= 1'b0;
      alu_r      <= 4'b0000;
      dest_r     <= {RADDR{1'b0}};
      rs_r       <= {RADDR{1'b0}};
      rt_r       <= {RADDR{1'b0}};
      rs_data_r  <= {XLEN{1'b0}};
      rt_data_r  <= {XLEN{1'b0}};
      imm_r      <= {XLEN{1'b0}};
      b_imm_r    <= 1'b0;
    end else if (!stall) begin
      valid_r    <= 1'b1;
      regwrite_r <= dec_regwrite_s;
      memread_r  <= dec_memread_s;
      memwrite_r <= dec_memwrite_s;
      ovf_en_r   <= dec_ovf_en_s;
      illegal_r  <= dec_illegal_s;
      alu_r      <= dec_alu_s;
      dest_r     <= dec_dest_s;
      rs_r       <= in_rs;
      rt_r       <= in_rt;
      rs_data_r  <= in_rs_data;
      rt_data_r  <= in_rt_data;
      imm_r      <= dec_imm_s;
      b_imm_r    <= dec_b_imm_s;
    end
  end

  // rs forwarding: EX/MEM has priority over MEM/WB; register 0 never forwards
  always_comb begin
    fwd_rs_s = rs_data_r;
    if (exmem_regwrite && (exmem_rd != {RADDR{1'b0}}) && (exmem_rd == rs_r)) begin
      fwd_rs_s = exmem_result;
    end else if (memwb_regwrite && (memwb_rd != {RADDR{1'b0}}) && (memwb_rd == rs_r)) begin
      fwd_rs_s = memwb_result;
    end else begin
      fwd_rs_s = rs_data_r;
    end
  end

  // rt forwarding: same priority rules as rs
  always_comb begin
    fwd_rt_s = rt_data_r;
    if (exmem_regwrite && (exmem_rd != {RADDR{1'b0}}) && (exmem_rd == rt_r)) begin
      fwd_rt_s = exmem_result;
    end else if (memwb_regwrite && (memwb_rd != {RADDR{1'b0}}) && (memwb_rd == rt_r)) begin
      fwd_rt_s = memwb_result;
    end else begin
      fwd_rt_s = rt_data_r;
    end
  end

  assign alu_a         = fwd_rs_s;
  assign alu_b         = b_imm_r ? imm_r : fwd_rt_s;
  assign ex_store_data = fwd_rt_s;
  assign alu_control   = alu_r;
  assign ex_valid      = valid_r;
  assign ex_regwrite   = regwrite_r;
  assign ex_memread    = memread_r;
  assign ex_memwrite   = memwrite_r;
  assign ex_ovf_en     = ovf_en_r;
  assign ex_illegal    = illegal_r;
  assign ex_dest       = dest_r;

  // A load in EX whose target is read by the instruction now in decode
  assign load_use_hazard = valid_r && memread_r && (dest_r != {RADDR{1'b0}}) && in_valid &&
                           ((in_rs == dest_r) || (in_rt == dest_r));

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: instruction-level reference model
// compared every cycle, plus hand-computed literal expectations.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, in_valid;
  logic [5:0]  in_opcode, in_funct;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [31:0] in_rs_data, in_rt_data;
  logic [15:0] in_imm;
  logic        exmem_regwrite, memwb_regwrite;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [3:0]  alu_control;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_ovf_en, ex_illegal;
  logic [4:0]  ex_dest;
  logic        load_use_hazard;

  int  n_vec = 0;
  int  n_err = 0;
  bit  check_en = 1'b0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .RADDR(5)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_opcode(in_opcode), .in_funct(in_funct), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_ovf_en(ex_ovf_en), .ex_illegal(ex_illegal),
    .ex_dest(ex_dest), .ex_store_data(ex_store_data), .load_use_hazard(load_use_hazard)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_ADD, M_ADDU, M_SUB, M_SUBU, M_AND, M_OR, M_XOR, M_SLT,
                M_ADDI, M_ADDIU, M_SLTI, M_ANDI, M_ORI, M_XORI,
                M_LW, M_SW, M_BEQ, M_BAD} mnem_t;

  function automatic mnem_t mnem(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      case (fn)
        6'h20: return M_ADD;  6'h21: return M_ADDU;
        6'h22: return M_SUB;  6'h23: return M_SUBU;
        6'h24: return M_AND;  6'h25: return M_OR;
        6'h26: return M_XOR;  6'h2A: return M_SLT;
        default: return M_BAD;
      endcase
    end
    case (op)
      6'h08: return M_ADDI;  6'h09: return M_ADDIU; 6'h0A: return M_SLTI;
      6'h0C: return M_ANDI;  6'h0D: return M_ORI;   6'h0E: return M_XORI;
      6'h23: return M_LW;    6'h2B: return M_SW;    6'h04: return M_BEQ;
      default: return M_BAD;
    endcase
  endfunction

  // Instruction held in EX (all zero for a bubble)
  logic        m_v;
  logic [5:0]  m_op, m_fn;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic [31:0] m_rsd, m_rtd;
  logic [15:0] m_imm;

  // Model state update with reset > flush > stall > load
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush || (!stall && !in_valid)) begin
      m_v <= 1'b0; m_op <= 6'd0; m_fn <= 6'd0; m_rs <= 5'd0; m_rt <= 5'd0; m_rd <= 5'd0;
      m_rsd <= 32'd0; m_rtd <= 32'd0; m_imm <= 16'd0;
    end else if (!stall) begin
      m_v <= 1'b1; m_op <= in_opcode; m_fn <= in_funct; m_rs <= in_rs; m_rt <= in_rt;
      m_rd <= in_rd; m_rsd <= in_rs_data; m_rtd <= in_rt_data; m_imm <= in_imm;
    end
  end

  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] rf);
    if (exmem_regwrite && exmem_rd != 5'd0 && exmem_rd == idx) return exmem_result;
    if (memwb_regwrite && memwb_rd != 5'd0 && memwb_rd == idx) return memwb_result;
    return rf;
  endfunction

  // Per-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (check_en) begin
      mnem_t m;
      logic [3:0] e_ctrl;
      logic [4:0] e_dest;
      logic [31:0] e_imm, e_b;
      logic e_hz;
      m = mnem(m_op, m_fn);
      case (m)
        M_SUB, M_SUBU, M_BEQ: e_ctrl = 4'b0110;
        M_AND, M_ANDI:        e_ctrl = 4'b0000;
        M_OR, M_ORI:          e_ctrl = 4'b0001;
        M_XOR, M_XORI:        e_ctrl = 4'b1100;
        M_SLT, M_SLTI:        e_ctrl = 4'b0111;
        default:              e_ctrl = 4'b0010;
      endcase
      if (!m_v) e_ctrl = 4'b0000;
      if (!m_v || m == M_BAD) e_dest = 5'd0;
      else if (m_op == 6'h00) e_dest = m_rd;
      else e_dest = m_rt;
      if (m == M_ANDI || m == M_ORI || m == M_XORI) e_imm = {16'd0, m_imm};
      else e_imm = {{16{m_imm[15]}}, m_imm};
      if (m_v && m inside {M_ADDI, M_ADDIU, M_SLTI, M_ANDI, M_ORI, M_XORI, M_LW, M_SW})
        e_b = e_imm;
      else
        e_b = fwd(m_rt, m_rtd);
      e_hz = m_v && m == M_LW && m_rt != 5'd0 && in_valid && (in_rs == m_rt || in_rt == m_rt);
      chk("valid",    {31'd0, ex_valid},    {31'd0, m_v});
      chk("regwrite", {31'd0, ex_regwrite}, {31'd0, m_v && !(m inside {M_SW, M_BEQ, M_BAD})});
      chk("memread",  {31'd0, ex_memread},  {31'd0, m_v && m == M_LW});
      chk("memwrite", {31'd0, ex_memwrite}, {31'd0, m_v && m == M_SW});
      chk("ovf_en",   {31'd0, ex_ovf_en},   {31'd0, m_v && (m inside {M_ADD, M_SUB, M_ADDI})});
      chk("illegal",  {31'd0, ex_illegal},  {31'd0, m_v && m == M_BAD});
      chk("alu_ctrl", {28'd0, alu_control}, {28'd0, e_ctrl});
      chk("dest",     {27'd0, ex_dest},     {27'd0, e_dest});
      chk("alu_a",    alu_a,                fwd(m_rs, m_rsd));
      chk("alu_b",    alu_b,                e_b);
      chk("store",    ex_store_data,        fwd(m_rt, m_rtd));
      chk("hazard",   {31'd0, load_use_hazard}, {31'd0, e_hz});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_instr(input logic v, input logic [5:0] op, input logic [5:0] fn,
                           input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [31:0] rsd, input logic [31:0] rtd, input logic [15:0] imm);
    in_valid = v; in_opcode = op; in_funct = fn; in_rs = rs; in_rt = rt; in_rd = rd;
    in_rs_data = rsd; in_rt_data = rtd; in_imm = imm;
  endtask

  task automatic fwd_idle();
    exmem_regwrite = 1'b0; exmem_rd = 5'd0; exmem_result = 32'd0;
    memwb_regwrite = 1'b0; memwb_rd = 5'd0; memwb_result = 32'd0;
  endtask

  logic [11:0] optab [0:16];

  initial begin
    optab[0]  = {6'h00, 6'h20}; optab[1]  = {6'h00, 6'h21}; optab[2]  = {6'h00, 6'h22};
    optab[3]  = {6'h00, 6'h23}; optab[4]  = {6'h00, 6'h24}; optab[5]  = {6'h00, 6'h25};
    optab[6]  = {6'h00, 6'h26}; optab[7]  = {6'h00, 6'h2A}; optab[8]  = {6'h08, 6'h00};
    optab[9]  = {6'h09, 6'h00}; optab[10] = {6'h0A, 6'h00}; optab[11] = {6'h0C, 6'h00};
    optab[12] = {6'h0D, 6'h00}; optab[13] = {6'h0E, 6'h00}; optab[14] = {6'h23, 6'h00};
    optab[15] = {6'h2B, 6'h00}; optab[16] = {6'h04, 6'h00};

    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    set_instr(1'b0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 16'd0);
    fwd_idle();
    tick(); tick();
    rst_n = 1'b1;
    check_en = 1'b1;
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_ctrl", {28'd0, alu_control}, 32'd0);
    tick();
    chk("post_rst_valid", {31'd0, ex_valid}, 32'd0);

    // add r3,r1,r2
    set_instr(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'h0000);
    tick();
    chk("add_a", alu_a, 32'd5);
    chk("add_b", alu_b, 32'd7);
    chk("add_ctrl", {28'd0, alu_control}, 32'h2);
    chk("add_dest", {27'd0, ex_dest}, 32'd3);
    chk("add_ovf", {31'd0, ex_ovf_en}, 32'd1);

    // andi / addi with 0x8001
    set_instr(1'b1, 6'h0C, 6'd0, 5'd1, 5'd4, 5'd0, 32'd9, 32'd9, 16'h8001);
    tick();
    chk("andi_b", alu_b, 32'h0000_8001);
    chk("andi_ctrl", {28'd0, alu_control}, 32'h0);
    set_instr(1'b1, 6'h08, 6'd0, 5'd1, 5'd4, 5'd0, 32'd9, 32'd9, 16'h8001);
    tick();
    chk("addi_b", alu_b, 32'hFFFF_8001);

    // forwarding priority on rs=4
    set_instr(1'b1, 6'h00, 6'h20, 5'd4, 5'd5, 5'd6, 32'h11, 32'h22, 16'd0);
    tick();
    exmem_regwrite = 1'b1; exmem_rd = 5'd4; exmem_result = 32'hAA;
    memwb_regwrite = 1'b1; memwb_rd = 5'd4; memwb_result = 32'hBB;
    #1 chk("fwd_exmem", alu_a, 32'hAA);
    exmem_regwrite = 1'b0;
    #1 chk("fwd_memwb", alu_a, 32'hBB);
    exmem_regwrite = 1'b1;
    set_instr(1'b1, 6'h00, 6'h20, 5'd0, 5'd5, 5'd6, 32'h33, 32'h22, 16'd0);
    tick();
    exmem_rd = 5'd0; memwb_rd = 5'd0;
    #1 chk("fwd_zero", alu_a, 32'h33);
    fwd_idle();

    // lw r8 then a consumer of r8
    set_instr(1'b1, 6'h23, 6'd0, 5'd1, 5'd8, 5'd0, 32'h100, 32'd0, 16'd4);
    tick();
    set_instr(1'b1, 6'h00, 6'h20, 5'd8, 5'd2, 5'd9, 32'd1, 32'd2, 16'd0);
    #1 chk("load_use", {31'd0, load_use_hazard}, 32'd1);
    flush = 1'b1; stall = 1'b1;
    tick();
    flush = 1'b0; stall = 1'b0;
    chk("flush_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_regwr", {31'd0, ex_regwrite}, 32'd0);

    // illegal opcode, then hold for 3 cycles
    set_instr(1'b1, 6'h3F, 6'd0, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 16'd0);
    tick();
    chk("ill_flag", {31'd0, ex_illegal}, 32'd1);
    chk("ill_regwr", {31'd0, ex_regwrite}, 32'd0);
    chk("ill_ctrl", {28'd0, alu_control}, 32'h2);
    stall = 1'b1;
    set_instr(1'b1, 6'h00, 6'h22, 5'd7, 5'd6, 5'd5, 32'd3, 32'd4, 16'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_ill", {31'd0, ex_illegal}, 32'd1);
      chk("stall_ctrl", {28'd0, alu_control}, 32'h2);
      chk("stall_valid", {31'd0, ex_valid}, 32'd1);
    end
    stall = 1'b0;

    // every legal opcode once, plus a bad funct and a bubble
    for (int i = 0; i < 17; i++) begin
      set_instr(1'b1, optab[i][11:6], optab[i][5:0], 5'd3, 5'd4, 5'd5,
                32'h1000 + i, 32'h2000 + i, 16'hF00F ^ i[15:0]);
      tick();
    end
    set_instr(1'b1, 6'h00, 6'h3F, 5'd3, 5'd4, 5'd5, 32'd1, 32'd2, 16'd0);
    tick();
    set_instr(1'b0, 6'h00, 6'h20, 5'd3, 5'd4, 5'd5, 32'd1, 32'd2, 16'd0);
    tick();

    // mixed traffic with forwarding, stalls and flushes
    for (int i = 0; i < 60; i++) begin
      int k;
      k = $urandom_range(0, 16);
      set_instr($urandom_range(0, 7) != 0, optab[k][11:6], optab[k][5:0],
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                $urandom, $urandom, 16'($urandom));
      exmem_regwrite = 1'($urandom_range(0, 1)); exmem_rd = 5'($urandom_range(0, 7));
      exmem_result = $urandom;
      memwb_regwrite = 1'($urandom_range(0, 1)); memwb_rd = 5'($urandom_range(0, 7));
      memwb_result = $urandom;
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 9) == 0);
      tick();
    end
    stall = 1'b0; flush = 1'b0;
    fwd_idle();

    // asynchronous reset in the middle of a cycle
    set_instr(1'b1, 6'h23, 6'd0, 5'd1, 5'd8, 5'd0, 32'h55, 32'h66, 16'h0010);
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, ex_valid}, 32'd0);
    chk("arst_memrd", {31'd0, ex_memread}, 32'd0);
    chk("arst_dest", {27'd0, ex_dest}, 32'd0);
    chk("arst_a", alu_a, 32'd0);
    chk("arst_b", alu_b, 32'd0);
    tick();
    rst_n = 1'b1;
    set_instr(1'b0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 16'd0);
    tick();
    chk("rel_valid", {31'd0, ex_valid}, 32'd0);
    tick();

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
